plane_div: RTL and testbench

Iterative fixed-point divider and plane-constant stage for the PVR triangle setup path. It takes the plane cross-product terms Aa, Ba and C and the first vertex from the setup arithmetic. It produces the per-pixel gradients FDDX = Aa/C and FDDY = Ba/C, plus the plane constant c. These three registered values feed the combinational plane interpolator directly downstream. A single shared-divisor datapath computes both quotients in parallel, one bit per clock.

---
 rtl/plane_div.sv | 201 ++++++++++++++++++++
 tb/tb_plane_div.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/plane_div.sv
// Iterative shared-divisor divider producing FDDX = Aa/C and FDDY = Ba/C (one
// quotient bit per clock for both), followed by the plane constant c.
module plane_div #(
  parameter int FRAC_BITS = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] Aa,
  input  logic signed [31:0] Ba,
  input  logic signed [31:0] C,
  input  logic signed [31:0] FX1,
  input  logic signed [31:0] FY1,
  input  logic signed [31:0] FZ1,
  output logic               busy,
  output logic               done,
  output logic               degenerate,
  output logic signed [31:0] FDDX,
  output logic signed [31:0] FDDY,
  output logic signed [31:0] c
);

  localparam int QW = 32 + FRAC_BITS;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {IDLE, DIV, FIX, PLANE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  degenerate_q, degenerate_d;
  logic                  deg_pend_q, deg_pend_d;
  logic signed [31:0]    fddx_q, fddx_d;
  logic signed [31:0]    fddy_q, fddy_d;
  logic signed [31:0]    c_q, c_d;

  logic [31:0]           remx_q, remx_d, remy_q, remy_d;
  logic [QW-1:0]         quox_q, quox_d, quoy_q, quoy_d;
  logic [31:0]           dvs_q, dvs_d;
  logic                  negx_q, negx_d, negy_q, negy_d;
  logic signed [31:0]    qx_q, qx_d, qy_q, qy_d;
  logic signed [31:0]    fx1_q, fx1_d, fy1_q, fy1_d, fz1_q, fz1_d;

  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    logic [31:0] u;
    u = v;
    return v[31] ? (~u + 32'd1) : u;
  endfunction

  // One restoring step: shift the next dividend bit into the remainder and
  // the quotient bit into the freed LSB of the dividend register.
  function automatic logic [32+QW-1:0] div_step(input logic [31:0] rem,
                                                input logic [QW-1:0] quo,
                                                input logic [31:0] dvs);
    logic [32:0] part;
    part = {rem, quo[QW-1]};
    if (part >= {1'b0, dvs}) begin
      part = part - {1'b0, dvs};
      return {part[31:0], quo[QW-2:0], 1'b1};
    end
    return {part[31:0], quo[QW-2:0], 1'b0};
  endfunction

  function automatic logic signed [31:0] sat_sign(input logic [QW-1:0] m,
                                                  input logic neg);
    if (neg) begin
      if (m > QW'(33'h0_8000_0000)) return 32'sh8000_0000;
      return $signed(~m[31:0] + 32'd1);
    end
    if (m > QW'(32'h7FFF_FFFF)) return 32'sh7FFF_FFFF;
    return $signed(m[31:0]);
  endfunction

  function automatic logic signed [31:0] plane_c(input logic signed [31:0] fz,
                                                 input logic signed [31:0] dx,
                                                 input logic signed [31:0] x,
                                                 input logic signed [31:0] dy,
                                                 input logic signed [31:0] y);
    logic signed [63:0] px, py;
    px = dx * x;
    py = dy * y;
    return fz - 32'(px >>> FRAC_BITS) - 32'(py >>> FRAC_BITS);
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    degenerate_d = degenerate_q;
    deg_pend_d   = deg_pend_q;
    fddx_d       = fddx_q;
    fddy_d       = fddy_q;
    c_d          = c_q;
    remx_d       = remx_q;
    remy_d       = remy_q;
    quox_d       = quox_q;
    quoy_d       = quoy_q;
    dvs_d        = dvs_q;
    negx_d       = negx_q;
    negy_d       = negy_q;
    qx_d         = qx_q;
    qy_d         = qy_q;
    fx1_d        = fx1_q;
    fy1_d        = fy1_q;
    fz1_d        = fz1_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          fx1_d      = FX1;
          fy1_d      = FY1;
          fz1_d      = FZ1;
          deg_pend_d = (C == 32'sd0);
          if (C == 32'sd0) begin
            qx_d    = '0;
            qy_d    = '0;
            state_d = PLANE;
          end else begin
            quox_d  = {mag32(Aa), {FRAC_BITS{1'b0}}};
            quoy_d  = {mag32(Ba), {FRAC_BITS{1'b0}}};
            remx_d  = '0;
            remy_d  = '0;
            dvs_d   = mag32(C);
            negx_d  = Aa[31] ^ C[31];
            negy_d  = Ba[31] ^ C[31];
            cnt_d   = '0;
            state_d = DIV;
          end
        end
      end
      // Divide stage: both numerators share the latched divisor
      DIV: begin
        {remx_d, quox_d} = div_step(remx_q, quox_q, dvs_q);
        {remy_d, quoy_d} = div_step(remy_q, quoy_q, dvs_q);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) state_d = FIX;
      end
      // Sign/saturate stage
      FIX: begin
        qx_d    = sat_sign(quox_q, negx_q);
        qy_d    = sat_sign(quoy_q, negy_q);
        state_d = PLANE;
      end
      // Plane-constant stage; results publish together with done
      PLANE: begin
        fddx_d       = qx_q;
        fddy_d       = qy_q;
        c_d          = plane_c(fz1_q, qx_q, fx1_q, qy_q, fy1_q);
        degenerate_d = deg_pend_q;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      degenerate_q <= 1'b0;
      deg_pend_q   <= 1'b0;
      fddx_q       <= '0;
      fddy_q       <= '0;
      c_q          <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      degenerate_q <= degenerate_d;
      deg_pend_q   <= deg_pend_d;
      fddx_q       <= fddx_d;
      fddy_q       <= fddy_d;
      c_q          <= c_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clock) begin
    remx_q <= remx_d;
    remy_q <= remy_d;
    quox_q <= quox_d;
    quoy_q <= quoy_d;
    dvs_q  <= dvs_d;
    negx_q <= negx_d;
    negy_q <= negy_d;
    qx_q   <= qx_d;
    qy_q   <= qy_d;
    fx1_q  <= fx1_d;
    fy1_q  <= fy1_d;
    fz1_q  <= fz1_d;
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign degenerate = degenerate_q;
  assign FDDX       = fddx_q;
  assign FDDY       = fddy_q;
  assign c          = c_q;

endmodule

// File: tb/tb_plane_div.sv
// Self-checking bench for plane_div: vector table with a result scoreboard plus
// hand-written sequences for ignored start and mid-job reset.
module tb_plane_div;

  typedef struct {
    logic [31:0] aa, ba, cc, fx1, fy1, fz1;
    logic [31:0] e_dx, e_dy, e_c;
    logic        e_deg;
    int          e_lat;
  } vec_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic signed [31:0] Aa, Ba, C, FX1, FY1, FZ1;
  logic               busy, done, degenerate;
  logic signed [31:0] FDDX, FDDY, c;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t vt[8];

  plane_div #(.FRAC_BITS(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .Aa(Aa), .Ba(Ba), .C(C), .FX1(FX1), .FY1(FY1), .FZ1(FZ1),
    .busy(busy), .done(done), .degenerate(degenerate),
    .FDDX(FDDX), .FDDY(FDDY), .c(c)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Scoreboard: each done pulse is matched against the oldest expected job.
  always @(negedge clock) begin
    vec_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("FDDX", FDDX, e.e_dx);
        chk("FDDY", FDDY, e.e_dy);
        chk("c", c, e.e_c);
        chk("degenerate", {31'd0, degenerate}, {31'd0, e.e_deg});
      end
    end
  end

  task automatic drive(input vec_t v);
    Aa  = v.aa;
    Ba  = v.ba;
    C   = v.cc;
    FX1 = v.fx1;
    FY1 = v.fy1;
    FZ1 = v.fz1;
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int lat;
    @(negedge clock);
    drive(v);
    start = 1'b1;
    sb.push_back(v);
    @(posedge clock);
    #1 start = 1'b0;
    chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(v.e_lat));
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    int lat;
    //        aa            ba            cc            fx1           fy1           fz1           e_dx          e_dy          e_c           deg  lat
    vt[0] = '{32'h00010000, 32'h00030000, 32'h00020000, 32'h0,        32'h0,        32'h00050000, 32'h00008000, 32'h00018000, 32'h00050000, 1'b0, 50};
    vt[1] = '{32'hFFFD0000, 32'h00010000, 32'h00020000, 32'h0,        32'h0,        32'h0,        32'hFFFE8000, 32'h00008000, 32'h0,        1'b0, 50};
    vt[2] = '{32'hFFFFFFFF, 32'h0,        32'h00000003, 32'h0,        32'h0,        32'h0,        32'hFFFFAAAB, 32'h0,        32'h0,        1'b0, 50};
    vt[3] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000001, 32'h0,        32'h0,        32'h0,        32'h7FFFFFFF, 32'h80000000, 32'h0,        1'b0, 50};
    vt[4] = '{32'h00050000, 32'h00070000, 32'h0,        32'h00010000, 32'h00020000, 32'h12345678, 32'h0,        32'h0,        32'h12345678, 1'b1, 1};
    vt[5] = '{32'h00010000, 32'h00020000, 32'h00010000, 32'h00030000, 32'h00010000, 32'h000A0000, 32'h00010000, 32'h00020000, 32'h00050000, 1'b0, 50};
    vt[6] = '{32'h00010000, 32'hFFFF0000, 32'hFFFC0000, 32'h00040000, 32'hFFF80000, 32'h00010000, 32'hFFFFC000, 32'h00004000, 32'h00040000, 1'b0, 50};
    vt[7] = '{32'h00010000, 32'h0,        32'h00020000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00008000, 32'h0,        32'h00000001, 1'b0, 50};

    reset = 1'b1;
    start = 1'b0;
    Aa = '0; Ba = '0; C = '0; FX1 = '0; FY1 = '0; FZ1 = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_degenerate", {31'd0, degenerate}, 32'd0);
    chk("reset_FDDX", FDDX, 32'd0);
    chk("reset_FDDY", FDDY, 32'd0);
    chk("reset_c", c, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_job(vt[i], $sformatf("vec%0d", i));

    // Second start at T10 must be ignored; outputs hold until done.
    @(negedge clock);
    drive(vt[1]);
    start = 1'b1;
    sb.push_back(vt[1]);
    @(posedge clock);
    #1 start = 1'b0;
    ndone = 0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock);
      #1;
      if (n == 9) begin
        drive(vt[4]);
        start = 1'b1;
      end
      if (n == 10) start = 1'b0;
      if (n == 25) chk("hold_FDDX_midjob", FDDX, 32'h00008000);
      if (done) begin
        ndone++;
        lat = n;
      end
    end
    chk("ignore_done_count", 32'(ndone), 32'd1);
    chk("ignore_latency", 32'(lat), 32'd50);

    // Reset at T20 of a job: outputs clear at once, no done follows.
    @(negedge clock);
    drive(vt[5]);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (19) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreset_FDDX", FDDX, 32'd0);
    chk("midreset_FDDY", FDDY, 32'd0);
    chk("midreset_c", c, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock);
      #1;
      if (done) ndone++;
    end
    chk("midreset_no_done", 32'(ndone), 32'd0);
    run_job(vt[0], "restart");

    repeat (3) @(posedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
